sbox_lane_scheduler: RTL and testbench



---
 rtl/sbox_lane_scheduler.sv | 146 ++++++++++++++
 tb/tb_sbox_lane_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_lane_scheduler.sv
// sbox_lane_scheduler: AES forward S-box engine shared by the cipher state (SubBytes) and
// key expansion (SubWord), LANES bytes per beat. Define SBOX_SCHED_PERF_EN for completion counters.
module sbox_lane_scheduler #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_rsp_valid,
  input  logic         st_rsp_ready,
  output logic [127:0] st_rsp_data,
  input  logic         kw_req_valid,
  output logic         kw_req_ready,
  input  logic [31:0]  kw_req_data,
  output logic         kw_rsp_valid,
  input  logic         kw_rsp_ready,
  output logic [31:0]  kw_rsp_data,
  output logic         busy,
  output logic         owner
`ifdef SBOX_SCHED_PERF_EN
  ,
  output logic [15:0]  st_done_cnt,
  output logic [15:0]  kw_done_cnt
`endif
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("sbox_lane_scheduler: LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state, state_nxt;
  logic [127:0] work, work_sub;
  logic [3:0]   idx, last_idx;
  logic         last_owner, grant_kw, req_hs, rsp_hs;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128 (maps 0 to 0), then the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Both beat counts are powers of two, so the final index always fits in four bits.
  assign last_idx = owner ? 4'(4 / LANES - 1) : 4'(16 / LANES - 1);
  assign grant_kw = kw_req_valid && (!st_req_valid || !last_owner);

  always_comb begin
    work_sub = work;
    for (int l = 0; l < LANES; l++) begin
      work_sub[((int'(idx) * LANES + l) & 15) * 8 +: 8] = sbox(work[((int'(idx) * LANES + l) & 15) * 8 +: 8]);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    st_req_ready = 1'b0;
    kw_req_ready = 1'b0;
    st_rsp_valid = 1'b0;
    kw_rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        st_req_ready = st_req_valid && !grant_kw;
        kw_req_ready = grant_kw;
        if ((st_req_valid && !grant_kw) || grant_kw) state_nxt = RUN;
      end
      RUN:  if (idx == last_idx) state_nxt = DONE;
      DONE: begin
        st_rsp_valid = !owner;
        kw_rsp_valid = owner;
        if ((!owner && st_rsp_ready) || (owner && kw_rsp_ready)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_hs      = (st_req_valid && st_req_ready) || (kw_req_valid && kw_req_ready);
  assign rsp_hs      = (st_rsp_valid && st_rsp_ready) || (kw_rsp_valid && kw_rsp_ready);
  assign st_rsp_data = work;
  assign kw_rsp_data = work[31:0];
  assign busy        = (state != IDLE);

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      work       <= '0;
      idx        <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_hs) begin
          work  <= grant_kw ? {96'h0, kw_req_data} : st_req_data;
          owner <= grant_kw;
          idx   <= '0;
        end
        RUN: begin
          work <= work_sub;
          idx  <= idx + 4'd1;
        end
        DONE: if (rsp_hs) last_owner <= owner;
        default: ;
      endcase
    end
  end

`ifdef SBOX_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_done_cnt <= '0;
      kw_done_cnt <= '0;
    end else begin
      if (st_rsp_valid && st_rsp_ready && st_done_cnt != 16'hFFFF) st_done_cnt <= st_done_cnt + 16'd1;
      if (kw_rsp_valid && kw_rsp_ready && kw_done_cnt != 16'hFFFF) kw_done_cnt <= kw_done_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sbox_lane_scheduler.sv
// Bench for sbox_lane_scheduler: FIPS-197 vectors, arbitration, backpressure, reset, and a
// randomized run against a transaction-level model (LANES=4 and LANES=1 instances).
module tb_sbox_lane_scheduler;

  localparam int L = 4;

  logic         clk, rst_n;
  logic         st_req_valid, st_req_ready, st_rsp_valid, st_rsp_ready;
  logic [127:0] st_req_data, st_rsp_data;
  logic         kw_req_valid, kw_req_ready, kw_rsp_valid, kw_rsp_ready;
  logic [31:0]  kw_req_data, kw_rsp_data;
  logic         busy, owner;

  logic         b_st_req_valid, b_st_req_ready, b_st_rsp_valid, b_st_rsp_ready;
  logic [127:0] b_st_req_data, b_st_rsp_data;
  logic         b_kw_req_valid, b_kw_req_ready, b_kw_rsp_valid, b_kw_rsp_ready;
  logic [31:0]  b_kw_req_data, b_kw_rsp_data;
  logic         b_busy, b_owner;

`ifdef SBOX_SCHED_PERF_EN
  logic [15:0] st_done_cnt, kw_done_cnt, b_st_done_cnt, b_kw_done_cnt;
`endif

  sbox_lane_scheduler #(.LANES(L)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_data(st_req_data),
    .st_rsp_valid(st_rsp_valid), .st_rsp_ready(st_rsp_ready), .st_rsp_data(st_rsp_data),
    .kw_req_valid(kw_req_valid), .kw_req_ready(kw_req_ready), .kw_req_data(kw_req_data),
    .kw_rsp_valid(kw_rsp_valid), .kw_rsp_ready(kw_rsp_ready), .kw_rsp_data(kw_rsp_data),
    .busy(busy), .owner(owner)
`ifdef SBOX_SCHED_PERF_EN
    , .st_done_cnt(st_done_cnt), .kw_done_cnt(kw_done_cnt)
`endif
  );

  sbox_lane_scheduler #(.LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid(b_st_req_valid), .st_req_ready(b_st_req_ready), .st_req_data(b_st_req_data),
    .st_rsp_valid(b_st_rsp_valid), .st_rsp_ready(b_st_rsp_ready), .st_rsp_data(b_st_rsp_data),
    .kw_req_valid(b_kw_req_valid), .kw_req_ready(b_kw_req_ready), .kw_req_data(b_kw_req_data),
    .kw_rsp_valid(b_kw_rsp_valid), .kw_rsp_ready(b_kw_rsp_ready), .kw_rsp_data(b_kw_rsp_data),
    .busy(b_busy), .owner(b_owner)
`ifdef SBOX_SCHED_PERF_EN
    , .st_done_cnt(b_st_done_cnt), .kw_done_cnt(b_kw_done_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_st_done, n_kw_done;
  logic [7:0] sbox_tab [256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference S-box: inverse found by exhaustive search, product reduced by the AES polynomial.
  function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv, c, s;
    inv = 8'h00;
    c   = 8'h63;
    for (int y = 1; y < 256; y++) if (gf_mul_ref(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
    return s;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] d, input int nbytes);
    logic [127:0] r;
    r = d;
    for (int k = 0; k < nbytes; k++) r[8*k +: 8] = sbox_tab[d[8*k +: 8]];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    st_req_valid = 0; st_req_data = '0; st_rsp_ready = 0;
    kw_req_valid = 0; kw_req_data = '0; kw_rsp_ready = 0;
    b_st_req_valid = 0; b_st_req_data = '0; b_st_rsp_ready = 0;
    b_kw_req_valid = 0; b_kw_req_data = '0; b_kw_rsp_ready = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_st_req_ready"}, st_req_ready, 0);
    check({tag, "_kw_req_ready"}, kw_req_ready, 0);
    check({tag, "_st_rsp_valid"}, st_rsp_valid, 0);
    check({tag, "_kw_rsp_valid"}, kw_rsp_valid, 0);
    check({tag, "_st_rsp_data"}, st_rsp_data, 0);
    check({tag, "_kw_rsp_data"}, kw_rsp_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_owner"}, owner, 0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  // One operation on the LANES=4 instance; checks grant, latency, data and return to idle.
  task automatic m_op(input bit key, input logic [127:0] d, input logic [127:0] exp,
                      input int lat, input string tag);
    int n;
    if (key) begin kw_req_valid = 1; kw_req_data = d[31:0]; end
    else     begin st_req_valid = 1; st_req_data = d; end
    #1;
    n = 0;
    while (!(key ? kw_req_ready : st_req_ready) && n < 50) begin step(); n++; end
    check({tag, "_granted"}, n < 50, 1);
    step();
    st_req_valid = 0; kw_req_valid = 0;
    n = 0;
    while (!(key ? kw_rsp_valid : st_rsp_valid) && n < 50) begin step(); n++; end
    check({tag, "_latency"}, n, lat);
    check({tag, "_data"}, key ? {96'h0, kw_rsp_data} : st_rsp_data, exp);
    st_rsp_ready = 1; kw_rsp_ready = 1;
    step();
    st_rsp_ready = 0; kw_rsp_ready = 0;
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic b_op(input bit key, input logic [127:0] d, input logic [127:0] exp,
                      input int lat, input string tag);
    int n;
    if (key) begin b_kw_req_valid = 1; b_kw_req_data = d[31:0]; end
    else     begin b_st_req_valid = 1; b_st_req_data = d; end
    #1;
    n = 0;
    while (!(key ? b_kw_req_ready : b_st_req_ready) && n < 50) begin step(); n++; end
    check({tag, "_granted"}, n < 50, 1);
    step();
    b_st_req_valid = 0; b_kw_req_valid = 0;
    n = 0;
    while (!(key ? b_kw_rsp_valid : b_st_rsp_valid) && n < 50) begin step(); n++; end
    check({tag, "_latency"}, n, lat);
    check({tag, "_data"}, key ? {96'h0, b_kw_rsp_data} : b_st_rsp_data, exp);
    b_st_rsp_ready = 1; b_kw_rsp_ready = 1;
    step();
    b_st_rsp_ready = 0; b_kw_rsp_ready = 0;
    check({tag, "_idle"}, b_busy, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] fips_in, fips_out, snap;
    int n, g, code;
    bit st_pend, kw_pend, m_busy, m_owner, m_last, g_st, g_kw, vld;
    logic [127:0] st_d, m_res;
    logic [31:0]  kw_d;
    int m_ready_at, cyc;

    fips_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    fips_out = 128'hd42711aee0bf98f1b8b45de51e415230;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_ref(8'(i));

    do_reset();

    // FIPS-197 vectors on both lane widths.
    m_op(0, fips_in, fips_out, 16 / L, "fips_st_l4");
    m_op(1, {96'h0, 32'hcf4f3c09}, {96'h0, 32'h8a84eb01}, 4 / L, "fips_kw_l4");
    b_op(1, {96'h0, 32'hcf4f3c09}, {96'h0, 32'h8a84eb01}, 4, "fips_kw_l1");
    b_op(0, fips_in, fips_out, 16, "fips_st_l1");

    // First tie after reset goes to state; key waits through backpressure and one idle bubble.
    do_reset();
    st_req_valid = 1; st_req_data = fips_in;
    kw_req_valid = 1; kw_req_data = 32'hcf4f3c09;
    #1;
    check("tie_st_ready", st_req_ready, 1);
    check("tie_kw_ready", kw_req_ready, 0);
    step();
    st_req_valid = 0;
    n = 0;
    while (!st_rsp_valid && n < 50) begin step(); n++; end
    check("tie_st_latency", n, 16 / L);
    snap = st_rsp_data;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", st_rsp_valid, 1);
      check("bp_data", st_rsp_data, snap);
      check("bp_busy", busy, 1);
      check("bp_kw_ready", kw_req_ready, 0);
      step();
    end
    check("bp_final_data", st_rsp_data, fips_out);
    st_rsp_ready = 1;
    step();
    st_rsp_ready = 0;
    check("bubble_kw_ready", kw_req_ready, 1);
    check("bubble_busy", busy, 0);
    step();
    kw_req_valid = 0;
    n = 0;
    while (!kw_rsp_valid && n < 50) begin step(); n++; end
    check("tie_kw_latency", n, 4 / L);
    check("tie_kw_data", kw_rsp_data, 32'h8a84eb01);
    kw_rsp_ready = 1;
    step();
    kw_rsp_ready = 0;

    // Continuous contention: grants must alternate S,K,S,K (code 4'b0101, state first).
    st_req_valid = 1; kw_req_valid = 1; st_rsp_ready = 1; kw_rsp_ready = 1;
    st_req_data = {$urandom, $urandom, $urandom, $urandom};
    kw_req_data = $urandom;
    #1;
    g = 0; code = 0; n = 0;
    while (g < 4 && n < 200) begin
      if (st_req_ready)      begin code = code * 2;     g++; end
      else if (kw_req_ready) begin code = code * 2 + 1; g++; end
      step();
      n++;
    end
    check("alt_count", g, 4);
    check("alt_order", code, 4'b0101);
    st_req_valid = 0; kw_req_valid = 0;
    n = 0;
    while (busy && n < 50) begin step(); n++; end
    check("alt_drain", busy, 0);
    st_rsp_ready = 0; kw_rsp_ready = 0;

    // Reset at beat 2 of a state operation; nothing stale may come out afterwards.
    st_req_valid = 1; st_req_data = fips_in;
    #1;
    step();
    st_req_valid = 0;
    step();
    step();
    check("midrun_busy", busy, 1);
    rst_n = 0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_reset_st_rsp", st_rsp_valid, 0);
      check("post_reset_kw_rsp", kw_rsp_valid, 0);
      check("post_reset_busy", busy, 0);
    end
    st_req_valid = 1; kw_req_valid = 1;
    #1;
    check("post_reset_tie_st", st_req_ready, 1);
    check("post_reset_tie_kw", kw_req_ready, 0);
    st_req_valid = 0; kw_req_valid = 0;

    // Randomized run against a transaction-level model.
    do_reset();
    st_pend = 0; kw_pend = 0; m_busy = 0; m_owner = 0; m_last = 1;
    m_ready_at = 0; m_res = '0; cyc = 0; st_d = '0; kw_d = '0;
    n_st_done = 0; n_kw_done = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!st_pend && $urandom_range(0, 3) == 0) begin
        st_pend = 1; st_d = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!kw_pend && $urandom_range(0, 3) == 0) begin
        kw_pend = 1; kw_d = $urandom;
      end
      st_req_valid = st_pend; st_req_data = st_d;
      kw_req_valid = kw_pend; kw_req_data = kw_d;
      st_rsp_ready = ($urandom_range(0, 2) != 0);
      kw_rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (!m_busy) begin
        g_st = st_req_valid && (!kw_req_valid || m_last);
        g_kw = kw_req_valid && (!st_req_valid || !m_last);
        check("rnd_st_req_ready", st_req_ready, g_st);
        check("rnd_kw_req_ready", kw_req_ready, g_kw);
        check("rnd_idle_busy", busy, 0);
        check("rnd_idle_rsp", {st_rsp_valid, kw_rsp_valid}, 0);
        if (g_st || g_kw) begin
          m_busy = 1;
          m_owner = g_kw;
          m_ready_at = cyc + 1 + (g_kw ? 4 / L : 16 / L);
          m_res = g_kw ? sub_bytes({96'h0, kw_d}, 4) : sub_bytes(st_d, 16);
          if (g_kw) kw_pend = 0; else st_pend = 0;
        end
      end else begin
        vld = (cyc >= m_ready_at);
        check("rnd_busy", busy, 1);
        check("rnd_owner", owner, m_owner);
        check("rnd_req_ready", {st_req_ready, kw_req_ready}, 0);
        check("rnd_st_rsp_valid", st_rsp_valid, vld && !m_owner);
        check("rnd_kw_rsp_valid", kw_rsp_valid, vld && m_owner);
        if (vld) begin
          if (m_owner) check("rnd_kw_data", kw_rsp_data, m_res[31:0]);
          else         check("rnd_st_data", st_rsp_data, m_res);
          if (m_owner ? kw_rsp_ready : st_rsp_ready) begin
            m_busy = 0;
            m_last = m_owner;
            if (m_owner) n_kw_done++; else n_st_done++;
          end
        end
      end
      @(posedge clk);
      cyc++;
      #1;
    end
    check("rnd_progress", (n_st_done > 3) && (n_kw_done > 3), 1);
    st_req_valid = 0; kw_req_valid = 0;
    if (m_busy) begin
      st_rsp_ready = 1; kw_rsp_ready = 1;
      n = 0;
      while (busy && n < 50) begin
        if ((st_rsp_valid && st_rsp_ready) || (kw_rsp_valid && kw_rsp_ready)) begin
          if (owner) n_kw_done++; else n_st_done++;
        end
        step();
        n++;
      end
      check("rnd_drain", busy, 0);
      st_rsp_ready = 0; kw_rsp_ready = 0;
    end

`ifdef SBOX_SCHED_PERF_EN
    check("perf_st_cnt", st_done_cnt, n_st_done);
    check("perf_kw_cnt", kw_done_cnt, n_kw_done);
    force u_dut4.st_done_cnt = 16'hFFFF;
    #1;
    release u_dut4.st_done_cnt;
    m_op(0, fips_in, fips_out, 16 / L, "perf_sat_op");
    check("perf_st_sat", st_done_cnt, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
